// File: rtl/iod_tx_train_pkg.sv
`default_nettype none
// ============================================================================
// Module  : iod_tx_train_pkg
// Purpose : Shared state type and default words for the TX IOD training lane.
// Revision: 1.0 - initial release
// ============================================================================
package iod_tx_train_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BIT_TRAIN = 2'd1,
        ST_SYNC      = 2'd2,
        ST_DATA      = 2'd3
    } iod_state_t;

    localparam logic [7:0] c_train_word = 8'h55;
    localparam logic [7:0] c_sync_word  = 8'hBC;
    localparam logic [7:0] c_idle_word  = 8'h00;

    // x^7 + x^6 + 1: feedback taps are bits 6 and 5 of the shift register
    localparam logic [6:0] c_prbs7_taps = 7'b110_0000;
    localparam logic [6:0] c_prbs7_seed = 7'h7F;

endpackage : iod_tx_train_pkg
`default_nettype wire

// File: rtl/iod_tx_prbs7.sv
`default_nettype none
// ============================================================================
// Module  : iod_tx_prbs7
// Purpose : Parallel PRBS7 source, DATA_WIDTH bits per advance, MSB first.
// Revision: 1.0 - initial release
// ============================================================================
module iod_tx_prbs7
    import iod_tx_train_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic                  i_advance,
    output logic [DATA_WIDTH-1:0] o_word
);

    logic [6:0]            r_lfsr;
    logic [6:0]            w_lfsr_next;
    logic [DATA_WIDTH-1:0] w_word;

    always_comb begin
        w_lfsr_next = r_lfsr;
        w_word      = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            w_word[i]   = ^(w_lfsr_next & c_prbs7_taps);
            w_lfsr_next = {w_lfsr_next[5:0], w_word[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_load) begin
            r_lfsr <= c_prbs7_seed;
        end else if (i_advance) begin
            r_lfsr <= w_lfsr_next;
        end
    end

    assign o_word = w_word;

endmodule : iod_tx_prbs7
`default_nettype wire

// File: rtl/iod_tx_train_gen.sv
`default_nettype none
// ============================================================================
// Module  : iod_tx_train_gen
// Purpose : TX IOD lane controller: bit training, word sync, then user data.
//           Define IOD_TX_TRAIN_PRBS_EN to send PRBS7 filler in DATA.
// Revision: 1.0 - initial release
// ============================================================================
module iod_tx_train_gen
    import iod_tx_train_pkg::*;
#(
    parameter int                    DATA_WIDTH       = 8,
    parameter logic [DATA_WIDTH-1:0] TRAIN_WORD       = DATA_WIDTH'(c_train_word),
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD        = DATA_WIDTH'(c_sync_word),
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD        = DATA_WIDTH'(c_idle_word),
    parameter int                    MIN_TRAIN_CYCLES = 64,
    parameter int                    SYNC_WORDS       = 16,
    parameter int                    TIMEOUT_WIDTH    = 20
) (
    input  logic                  SCLK,
    input  logic                  RESETN,
    input  logic                  PLL_LOCK,
    input  logic                  TX_TRAIN_REQ,
    input  logic                  RX_ALGN_DONE,
    input  logic [DATA_WIDTH-1:0] TX_DATA_IN,
    input  logic                  TX_DATA_VALID,
    output logic                  TX_DATA_READY,
    output logic [DATA_WIDTH-1:0] TX_DATA_OUT,
    output logic                  TX_TRAIN_ACTIVE,
    output logic                  TX_LINK_UP,
    output logic                  TX_TRAIN_ERR
);

    localparam int TCW = (MIN_TRAIN_CYCLES > 1) ? $clog2(MIN_TRAIN_CYCLES) : 1;
    localparam int SCW = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;
    localparam logic [TCW-1:0] c_train_last = TCW'(MIN_TRAIN_CYCLES - 1);
    localparam logic [SCW-1:0] c_sync_last  = SCW'(SYNC_WORDS - 1);

    iod_state_t              r_state;
    logic [TCW-1:0]          r_train_cnt;
    logic [SCW-1:0]          r_sync_cnt;
    logic [TIMEOUT_WIDTH-1:0] r_to_cnt;
    logic                    r_train_err;
    logic [DATA_WIDTH-1:0]   r_tx_data;
    logic [DATA_WIDTH-1:0]   w_filler;
    logic                    w_restart;

    assign w_restart = TX_TRAIN_REQ && (r_state != ST_IDLE);

`ifdef IOD_TX_TRAIN_PRBS_EN
    logic w_prbs_load;
    logic w_prbs_adv;

    // Reseed on the edge that enters DATA; step only when a filler word is sent
    assign w_prbs_load = PLL_LOCK && !w_restart && (r_state == ST_SYNC) &&
                         RX_ALGN_DONE && (r_sync_cnt == c_sync_last);
    assign w_prbs_adv  = PLL_LOCK && !w_restart && (r_state == ST_DATA) &&
                         RX_ALGN_DONE && !TX_DATA_VALID;

    iod_tx_prbs7 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_prbs7 (
        .clk       (SCLK),
        .rst_n     (RESETN),
        .i_load    (w_prbs_load),
        .i_advance (w_prbs_adv),
        .o_word    (w_filler)
    );
`else
    assign w_filler = IDLE_WORD;
`endif

    always_ff @(posedge SCLK) begin
        if (!RESETN) begin
            r_state     <= ST_IDLE;
            r_train_cnt <= '0;
            r_sync_cnt  <= '0;
            r_to_cnt    <= '0;
            r_train_err <= 1'b0;
            r_tx_data   <= IDLE_WORD;
        end else if (!PLL_LOCK) begin
            r_state     <= ST_IDLE;
            r_train_cnt <= '0;
            r_sync_cnt  <= '0;
            r_to_cnt    <= '0;
            r_tx_data   <= IDLE_WORD;
        end else if (w_restart) begin
            r_state     <= ST_BIT_TRAIN;
            r_train_cnt <= '0;
            r_sync_cnt  <= '0;
            r_to_cnt    <= '0;
            r_train_err <= 1'b0;
            r_tx_data   <= TRAIN_WORD;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state     <= ST_BIT_TRAIN;
                    r_train_cnt <= '0;
                    r_sync_cnt  <= '0;
                    r_to_cnt    <= '0;
                    r_tx_data   <= TRAIN_WORD;
                end
                ST_BIT_TRAIN: begin
                    if ((r_train_cnt == c_train_last) && RX_ALGN_DONE) begin
                        r_state     <= ST_SYNC;
                        r_train_cnt <= '0;
                        r_sync_cnt  <= '0;
                        r_to_cnt    <= '0;
                        r_tx_data   <= SYNC_WORD;
                    end else begin
                        if (r_train_cnt != c_train_last) begin
                            r_train_cnt <= r_train_cnt + 1'b1;
                        end
                        // Timeout flags the error but keeps training; counter wraps
                        if (&r_to_cnt) begin
                            r_train_err <= 1'b1;
                            r_to_cnt    <= '0;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                        r_tx_data <= TRAIN_WORD;
                    end
                end
                ST_SYNC: begin
                    if (!RX_ALGN_DONE) begin
                        r_state     <= ST_BIT_TRAIN;
                        r_train_cnt <= '0;
                        r_sync_cnt  <= '0;
                        r_to_cnt    <= '0;
                        r_tx_data   <= TRAIN_WORD;
                    end else if (r_sync_cnt == c_sync_last) begin
                        r_state   <= ST_DATA;
                        r_tx_data <= IDLE_WORD;
                    end else begin
                        r_sync_cnt <= r_sync_cnt + 1'b1;
                        r_tx_data  <= SYNC_WORD;
                    end
                end
                ST_DATA: begin
                    if (!RX_ALGN_DONE) begin
                        r_state     <= ST_BIT_TRAIN;
                        r_train_cnt <= '0;
                        r_sync_cnt  <= '0;
                        r_to_cnt    <= '0;
                        r_tx_data   <= TRAIN_WORD;
                    end else if (TX_DATA_VALID) begin
                        r_tx_data <= TX_DATA_IN;
                    end else begin
                        r_tx_data <= w_filler;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_tx_data <= IDLE_WORD;
                end
            endcase
        end
    end

    assign TX_DATA_OUT     = r_tx_data;
    assign TX_TRAIN_ERR    = r_train_err;
    assign TX_DATA_READY   = (r_state == ST_DATA);
    assign TX_LINK_UP      = (r_state == ST_DATA);
    assign TX_TRAIN_ACTIVE = (r_state == ST_BIT_TRAIN) || (r_state == ST_SYNC);

endmodule : iod_tx_train_gen
`default_nettype wire
